// File: rtl/timer_irq.sv
// Programmable interval timer with an interrupt-request latch.
// A prescaler counter (pc) divides the clock down to ticks, and a period
// counter (count) divides ticks down to expiries. Each expiry can raise
// i_timer. i_timer stays high until the CPU acknowledges the request through
// s_finish_interr. An expiry that arrives while a request is still pending
// sets the sticky 'missed' flag.
module timer_irq #(
  parameter int PRESC_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [7:0]       wdata,
  input  logic             s_finish_interr,
  output logic             i_timer,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             missed
);

  typedef enum logic [1:0] {
    ADDR_PRESC   = 2'd0,
    ADDR_PERIOD  = 2'd1,
    ADDR_CTRL    = 2'd2,
    ADDR_RESTART = 2'd3
  } addr_e;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0]   period;
  logic [PRESC_W-1:0] pc;
  logic [CNT_W-1:0]   count_q;
  logic               en;
  logic               oneshot;
  logic               irq_en;
  logic               missed_q;
  state_e             state_q;
  state_e             state_d;

  logic ctrl_wr;
  logic clr;
  logic tick;
  logic expire;
  logic irq_event;

  // Decode register writes, then derive tick, expiry and request events.
  // A write that clears the counters suppresses the tick and expiry of that cycle.
  assign ctrl_wr   = we && (addr_e'(addr) == ADDR_CTRL);
  assign clr       = we && (addr_e'(addr) != ADDR_CTRL);
  assign tick      = en && !clr && (pc == presc);
  assign expire    = tick && (count_q == period);
  assign irq_event = expire && irq_en;

  // Hold the PRESC and PERIOD configuration registers.
  // NOTE: sequential state is written with non-blocking assignments, so all
  // flops in a clocked block sample the pre-edge values of their inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      period <= '0;
    end else if (we) begin
      if (addr_e'(addr) == ADDR_PRESC)  presc  <= PRESC_W'(wdata);
      if (addr_e'(addr) == ADDR_PERIOD) period <= CNT_W'(wdata);
    end
  end

  // Hold the CTRL bits. An expiry in one-shot mode drops 'en', unless a CTRL
  // write on the same edge supplies a new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      irq_en  <= 1'b0;
    end else if (ctrl_wr) begin
      en      <= wdata[0];
      oneshot <= wdata[1];
      irq_en  <= wdata[2];
    end else if (expire && oneshot) begin
      en      <= 1'b0;
    end
  end

  // Run the prescaler and period counters. They are cleared by a write to
  // PRESC, PERIOD or RESTART and hold while the timer is disabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pc      <= '0;
      count_q <= '0;
    end else if (en) begin
      pc <= tick ? '0 : pc + PRESC_W'(1);
      if (tick) count_q <= expire ? '0 : count_q + CNT_W'(1);
    end
  end

  // Hold the request-FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Compute the next request state. A new event wins over a simultaneous ack,
  // so the fresh request is served next.
  // NOTE: state_d takes a default before any branch, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (irq_event) state_d = PEND;
      PEND: if (s_finish_interr && !irq_event) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Maintain the sticky lost-expiry flag. When a set condition and a clear
  // write land on the same edge, the set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      missed_q <= 1'b0;
    end else if (state_q == PEND && irq_event && !s_finish_interr) begin
      missed_q <= 1'b1;
    end else if (ctrl_wr && wdata[3]) begin
      missed_q <= 1'b0;
    end
  end

  assign i_timer = (state_q == PEND);
  assign count   = count_q;
  assign running = en;
  assign missed  = missed_q;

endmodule

// File: tb/tb_timer_irq.sv
// Directed self-checking bench for timer_irq. Inputs are driven 1 ns after
// each rising edge, and outputs are sampled at that same point.
module tb_timer_irq;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       s_finish_interr;
  logic       i_timer;
  logic [7:0] count;
  logic       running;
  logic       missed;

  int n_cmp = 0;
  int n_bad = 0;

  timer_irq #(.PRESC_W(8), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .s_finish_interr(s_finish_interr),
    .i_timer(i_timer),
    .count(count),
    .running(running),
    .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle register write. The write takes effect on the next edge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0; addr = 2'd0; wdata = 8'd0;
  endtask

  task automatic ack();
    s_finish_interr = 1'b1;
    step();
    s_finish_interr = 1'b0;
  endtask

  logic [7:0] exp_cnt [1:6] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0};
  logic       seen;

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 8'd0; s_finish_interr = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_i_timer", i_timer, 0);
    check("rst_count",   count,   0);
    check("rst_running", running, 0);
    check("rst_missed",  missed,  0);

    // Auto-reload, P=1 N=2: expiry every 6 edges.
    wr(2'd0, 8'd1);
    wr(2'd1, 8'd2);
    wr(2'd2, 8'h05);
    check("ar_running", running, 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("ar_count_e%0d", k), count, exp_cnt[k]);
      check($sformatf("ar_irq_e%0d", k), i_timer, (k == 6) ? 1 : 0);
    end
    ack();
    check("ar_ack_fall", i_timer, 0);
    for (int k = 8; k <= 11; k++) step();
    check("ar_before_2nd", i_timer, 0);
    step();
    check("ar_2nd_rise", i_timer, 1);
    ack();
    check("ar_ack2_fall", i_timer, 0);
    wr(2'd2, 8'h00);

    // One-shot, P=0 N=3: expiry on the 4th edge, and 'en' drops on that edge.
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd3);
    wr(2'd2, 8'h07);
    step(); step(); step();
    check("os_e3_irq", i_timer, 0);
    check("os_e3_running", running, 1);
    check("os_e3_count", count, 3);
    step();
    check("os_e4_irq", i_timer, 1);
    check("os_e4_running", running, 0);
    ack();
    check("os_ack_fall", i_timer, 0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (i_timer) seen = 1'b1;
    end
    check("os_no_repeat", seen, 0);
    check("os_count_frozen", count, 0);

    // Missed expiry, P=0 N=1, auto-reload, no ack.
    wr(2'd1, 8'd1);
    wr(2'd2, 8'h05);
    step();
    check("ms_e1_irq", i_timer, 0);
    step();
    check("ms_e2_irq", i_timer, 1);
    check("ms_e2_missed", missed, 0);
    step();
    check("ms_e3_missed", missed, 0);
    step();
    check("ms_e4_missed", missed, 1);
    wr(2'd2, 8'h0D);
    check("ms_clear", missed, 0);
    check("ms_clear_irq", i_timer, 1);
    check("ms_clear_running", running, 1);
    step();
    check("ms_reset_again", missed, 1);
    wr(2'd2, 8'h0D);
    check("ms_clear2", missed, 0);
    ack();
    check("ms_ack_on_exp_irq", i_timer, 1);
    check("ms_ack_on_exp_missed", missed, 0);
    we = 1'b1; addr = 2'd2; wdata = 8'h00; s_finish_interr = 1'b1;
    step();
    we = 1'b0; addr = 2'd0; wdata = 8'd0; s_finish_interr = 1'b0;
    check("ms_final_ack", i_timer, 0);
    check("ms_disabled", running, 0);

    // Silent mode: P=0 N=0, irq disabled.
    wr(2'd1, 8'd0);
    wr(2'd2, 8'h01);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (count != 8'd0 || i_timer || missed) seen = 1'b1;
    end
    check("silent_quiet", seen, 0);
    check("silent_running", running, 1);
    wr(2'd2, 8'h00);

    // Rewrite and restart with P=0 N=5.
    wr(2'd1, 8'd5);
    wr(2'd2, 8'h05);
    step(); step();
    check("rw_count2", count, 2);
    wr(2'd1, 8'd5);
    check("rw_period_clr", count, 0);
    for (int k = 0; k < 5; k++) step();
    check("rw_before_exp", i_timer, 0);
    step();
    check("rw_full_exp", i_timer, 1);
    ack();
    step();
    check("rs_count2", count, 2);
    wr(2'd3, 8'hA5);
    check("rs_clr", count, 0);
    check("rs_running", running, 1);
    for (int k = 0; k < 5; k++) step();
    check("rs_before_exp", i_timer, 0);
    step();
    check("rs_full_exp", i_timer, 1);
    ack();
    wr(2'd2, 8'h00);
    check("frz_count", count, 2);
    for (int k = 0; k < 5; k++) step();
    check("frz_hold", count, 2);

    // A RESTART write landing on an expiry edge wins: no request is raised.
    wr(2'd2, 8'h05);
    step(); step(); step();
    check("pri_count5", count, 5);
    wr(2'd3, 8'h00);
    check("pri_count0", count, 0);
    check("pri_no_irq", i_timer, 0);
    wr(2'd2, 8'h00);

    // Reset while PEND with missed set.
    wr(2'd1, 8'd0);
    wr(2'd2, 8'h05);
    step(); step();
    check("rp_irq", i_timer, 1);
    check("rp_missed", missed, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rp_i_timer", i_timer, 0);
    check("rp_count",   count,   0);
    check("rp_running", running, 0);
    check("rp_missed0", missed,  0);
    step(); step(); step();
    check("rp_stopped_irq", i_timer, 0);
    check("rp_stopped_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
# timer_irq

Programmable interval timer that produces the `i_timer` interrupt request consumed by the CPU datapath's interruption module and stack-context switching. It has an 8-bit prescaler and an 8-bit period counter, one-shot or auto-reload modes, and a pending-request latch held until the CPU signals end of service through `s_finish_interr`. It also has a sticky flag that records an expiry arriving while a request is still pending. The CPU configures it through a small register-write port driven from an output port.

## Interface
- `PRESC_W`, default 8: prescaler register/counter width.
- `CNT_W`, default 8: period register/counter width.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high. One clock, `clk`.
- `we`: input, 1 bit. Register write strobe, one cycle per write.
- `addr`: input, 2 bits. Register select:
  - 0: PRESC
  - 1: PERIOD
  - 2: CTRL
  - 3: RESTART
- `wdata`: input, 8 bits. Write data. Only the low `PRESC_W`/`CNT_W` bits are used.
- `s_finish_interr`: input, 1 bit. End-of-service acknowledge from the control unit, one-cycle pulse.
- `i_timer`: output, 1 bit. Interrupt request level to the datapath.
- `count`: output, `CNT_W` bits. Current period counter value.
- `running`: output, 1 bit. CTRL.en.
- `missed`: output, 1 bit. Sticky lost-expiry flag.

## Operation
- Registers:
  - PRESC = P.
  - PERIOD = N.
  - CTRL bits:
    - bit0 `en`
    - bit1 `oneshot`
    - bit2 `irq_en`
    - bit3 write-1-to-clear `missed`; this bit is not stored.
  - RESTART: a write with any data clears the prescaler counter `pc` and `count`. CTRL is unchanged.
- Writes to PRESC or PERIOD also clear `pc` and `count`.
- Writes to CTRL do not touch `pc` or `count`.
- Counting, in each cycle with `en`=1 and no write clearing the counters:
  - If `pc`==P: `pc`<=0 (tick). Otherwise `pc`<=`pc`+1.
  - On a tick:
    - If `count`==N: `count`<=0 (expiry).
    - Otherwise `count`<=`count`+1.
- With `en`=0, `pc` and `count` hold.
- Boundary values:
  - P=0 ticks every enabled cycle.
  - N=0 expires on every tick.
  - All compares are equality, so there is no overflow path; counters never exceed their register value unless the register is rewritten. Because rewrites clear the counters, they cannot exceed it in practice.
- Expiry side effects:
  - If `oneshot`=1, `en`<=0 on the same edge.
  - If `irq_en`=1, the request FSM sees an event.
  - If `irq_en`=0, the expiry is silent: `i_timer` stays 0 and `missed` is not touched.
- Request FSM has two states, IDLE (`i_timer`=0) and PEND (`i_timer`=1):
  - IDLE + event → PEND.
  - PEND + `s_finish_interr` without event → IDLE.
  - PEND + event without ack → stay PEND, `missed`<=1.
  - PEND + event + ack in the same cycle → stay PEND (new request served next), `missed` unchanged.
  - IDLE + ack → ignored.
- Clearing `irq_en` while in PEND does not drop `i_timer`. Only an ack or `reset` leaves PEND.
- `missed` clearing:
  - Cleared only by a CTRL write with bit3=1, or by `reset`.
  - If that write coincides with a setting condition, set wins.

## Timing
- Reset values:
  - `pc`=0, `count`=0.
  - P=0, N=0.
  - CTRL=0: `running`=0.
  - FSM in IDLE: `i_timer`=0.
  - `missed`=0.
- Register writes take effect at the edge where `we`=1. The new values are visible the following cycle.
- Counters run on the first cycle after the edge that set `en`.
- Expiry latency: `i_timer` is 1 after the (P+1)·(N+1)-th rising edge following the enabling edge. In auto-reload it repeats every (P+1)·(N+1) cycles.
- `i_timer` is registered, with no combinational path from any input.
- Ack latency: `i_timer` falls on the edge that samples `s_finish_interr`=1.
- A counter-clearing write in the same cycle as a would-be tick or expiry wins: no expiry, counters become 0.
- `reset` mid-count or in PEND returns all state to reset values at that edge.

## Test plan
- Reset, then write P=1, N=2, CTRL=0x05 (auto-reload, irq on) → `i_timer` rises 6 edges after the CTRL write. Ack one cycle later → `i_timer` falls. `i_timer` rises again 6 cycles after the previous rise, and `count` sequence 0,0,1,1,2,2,0… is observed.
- One-shot: P=0, N=3, CTRL=0x07 → `i_timer` rises after 4 edges and `running` drops on the same edge. After ack, no further request for 50 cycles.
- Missed expiry: P=0, N=1, auto-reload, never ack → `i_timer` at edge 2, `missed`=1 at edge 4. CTRL write 0x0D clears `missed` and it re-sets 2 cycles later. Ack coinciding with an expiry edge → `i_timer` stays 1 and `missed` unchanged.
- Silent mode: CTRL=0x01, P=0, N=0 for 20 cycles → `count` stays 0, `i_timer`=0, `missed`=0.
- Rewriting the registers: writing PERIOD, or writing RESTART, at `count`=2 with N=5 → `count`=0 next cycle, and the next expiry is a full (P+1)·(N+1) later. `en`=0 freezes `count`.
- `reset` asserted while in PEND with `missed`=1 → next cycle all outputs are 0 and counting has stopped.
